// File: rtl/lcd_arb_pkg.sv
// lcd_arb_pkg: shared definitions for the LCD bus arbiter.
//   arb_state_e  - arbiter FSM states
//   CLI_*        - client index constants (0 = init, 1 = picture, 2 = char)
//   LCD_DATA_W   - SPI writer word width {dc, byte[7:0]}
package lcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WAIT_DONE,
    RELEASE
  } arb_state_e;

  localparam int unsigned CLI_INIT   = 0;
  localparam int unsigned CLI_PIC    = 1;
  localparam int unsigned CLI_CHAR   = 2;
  localparam int unsigned LCD_DATA_W = 9;

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// lcd_bus_arbiter_if: client-side and SPI-writer-side signals of the arbiter.
//   init_done    - panel initialisation complete (level)
//   cli_req      - per-client bus request (level)
//   cli_en       - per-client write strobe (one cycle)
//   cli_data     - packed client words, client k at [k*DATA_W +: DATA_W]
//   cli_grant    - one-hot grant or all-zero
//   cli_wr_done  - per-client write-complete pulse
//   data         - word to the SPI writer
//   en_write     - one-cycle write strobe to the SPI writer
//   wr_done      - SPI writer completion pulse
//   busy         - arbiter not idle
//   timeout_err  - watchdog pulse
// Modports: slave = arbiter side, master = clients/SPI-writer side.
interface lcd_bus_arbiter_if
  import lcd_arb_pkg::*;
#(
  parameter int unsigned N_CLI  = 3,
  parameter int unsigned DATA_W = LCD_DATA_W
);
  logic                      init_done;
  logic [N_CLI-1:0]          cli_req;
  logic [N_CLI-1:0]          cli_en;
  logic [N_CLI*DATA_W-1:0]   cli_data;
  logic [N_CLI-1:0]          cli_grant;
  logic [N_CLI-1:0]          cli_wr_done;
  logic [DATA_W-1:0]         data;
  logic                      en_write;
  logic                      wr_done;
  logic                      busy;
  logic                      timeout_err;

  modport slave (
    input  init_done, cli_req, cli_en, cli_data, wr_done,
    output cli_grant, cli_wr_done, data, en_write, busy, timeout_err
  );

  modport master (
    output init_done, cli_req, cli_en, cli_data, wr_done,
    input  cli_grant, cli_wr_done, data, en_write, busy, timeout_err
  );
endinterface

// File: rtl/lcd_arb_rr.sv
// lcd_arb_rr: combinational round-robin picker.
//   req_i    - request vector
//   ptr_i    - one-hot pointer, highest-priority position
//   choice_o - one-hot choice (zero when no request)
module lcd_arb_rr #(
  parameter int unsigned N_CLI = 3
) (
  input  logic [N_CLI-1:0] req_i,
  input  logic [N_CLI-1:0] ptr_i,
  output logic [N_CLI-1:0] choice_o
);
  logic [N_CLI-1:0] mask_hi;
  logic [N_CLI-1:0] req_hi;

  // Requests at or above the pointer win; otherwise wrap to the lowest request.
  // x & (~x + 1) isolates the lowest set bit.
  always_comb begin
    mask_hi = ~(ptr_i - N_CLI'(1));
    req_hi  = req_i & mask_hi;
    if (|req_hi) choice_o = req_hi & (~req_hi + N_CLI'(1));
    else         choice_o = req_i & (~req_i + N_CLI'(1));
  end
endmodule

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: grants the shared SPI writer to one of N_CLI clients.
// Client 0 (init) has fixed top priority and is the only eligible client
// before init_done; the remaining clients share the bus round-robin. A grant
// is held while the client keeps cli_req high and is followed by a one-cycle
// RELEASE gap.
// Ports: sys_clk_50MHz (clock), sys_rst (sync active-high reset),
//        bus (lcd_bus_arbiter_if.slave, see interface header).
// Optional feature: define LCD_ARB_WDOG_EN to enable the WAIT_DONE watchdog
// (timeout after WDOG_CYCLES clocks); otherwise timeout_err is tied to 0.
module lcd_bus_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int unsigned DATA_W      = LCD_DATA_W,
  parameter int unsigned N_CLI       = 3,
  parameter int unsigned WDOG_CYCLES = 65535
) (
  input  logic                     sys_clk_50MHz,
  input  logic                     sys_rst,
  lcd_bus_arbiter_if.slave         bus
);
  localparam logic [N_CLI-1:0] INIT_OH = N_CLI'(1) << CLI_INIT;
  localparam logic [N_CLI-1:0] PIC_OH  = N_CLI'(1) << CLI_PIC;

  if (WDOG_CYCLES == 0) begin : g_bad_wdog_cfg
    $error("lcd_bus_arbiter: WDOG_CYCLES must be at least 1");
  end

  arb_state_e        state_q, state_d;
  logic [N_CLI-1:0]  gnt_q, gnt_d;
  logic [N_CLI-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              en_write_q, en_write_d;
  logic [N_CLI-1:0]  wr_done_q, wr_done_d;

  logic [N_CLI-1:0]  eligible;
  logic [N_CLI-1:0]  rr_choice;
  logic [N_CLI-1:0]  pick;
  logic [N_CLI-1:0]  pick_next;
  logic [DATA_W-1:0] gnt_word;
  logic              gnt_req;
  logic              gnt_en;

`ifdef LCD_ARB_WDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              timeout_q, timeout_d;
`endif

  lcd_arb_rr #(.N_CLI(N_CLI)) u_rr (
    .req_i    (eligible),
    .ptr_i    (ptr_q),
    .choice_o (rr_choice)
  );

  always_comb begin
    eligible = bus.init_done ? bus.cli_req : (bus.cli_req & INIT_OH);
    pick     = eligible[CLI_INIT] ? INIT_OH : rr_choice;
    // Pointer moves just past the winner; wrapping skips client 0.
    pick_next = pick << 1;
    if (pick_next == '0) pick_next = PIC_OH;
    gnt_req  = |(bus.cli_req & gnt_q);
    gnt_en   = |(bus.cli_en & gnt_q);
    gnt_word = '0;
    for (int unsigned c = 0; c < N_CLI; c++) begin
      if (gnt_q[c]) gnt_word = bus.cli_data[c*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    data_d     = data_q;
    en_write_d = 1'b0;
    wr_done_d  = '0;
`ifdef LCD_ARB_WDOG_EN
    wd_cnt_d   = wd_cnt_q;
    timeout_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d = GRANT;
          gnt_d   = pick;
          ptr_d   = pick_next;
        end
      end
      GRANT: begin
        // A strobe coinciding with a req drop still gets written out.
        if (gnt_en) begin
          data_d     = gnt_word;
          en_write_d = 1'b1;
          state_d    = WAIT_DONE;
`ifdef LCD_ARB_WDOG_EN
          wd_cnt_d   = '0;
`endif
        end else if (!gnt_req) begin
          state_d = RELEASE;
        end
      end
      WAIT_DONE: begin
        if (bus.wr_done) begin
          wr_done_d = gnt_q;
          state_d   = gnt_req ? GRANT : RELEASE;
        end
`ifdef LCD_ARB_WDOG_EN
        else if (wd_cnt_q == WD_W'(WDOG_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = RELEASE;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
`endif
      end
      RELEASE: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_50MHz) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      ptr_q      <= PIC_OH;
      data_q     <= '0;
      en_write_q <= 1'b0;
      wr_done_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      data_q     <= data_d;
      en_write_q <= en_write_d;
      wr_done_q  <= wr_done_d;
    end
  end

`ifdef LCD_ARB_WDOG_EN
  always_ff @(posedge sys_clk_50MHz) begin
    if (sys_rst) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.timeout_err = timeout_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.cli_grant   = (state_q == GRANT || state_q == WAIT_DONE) ? gnt_q : '0;
  assign bus.cli_wr_done = wr_done_q;
  assign bus.data        = data_q;
  assign bus.en_write    = en_write_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: directed self-checking bench for lcd_bus_arbiter.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_lcd_bus_arbiter;
  import lcd_arb_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #10 clk = ~clk;

  lcd_bus_arbiter_if #(.N_CLI(N), .DATA_W(DW)) bus ();

  lcd_bus_arbiter #(.DATA_W(DW), .N_CLI(N), .WDOG_CYCLES(16)) dut (
    .sys_clk_50MHz (clk),
    .sys_rst       (rst),
    .bus           (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int unsigned k, input logic [DW-1:0] w);
    bus.cli_data[k*DW +: DW] = w;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".grant"},   32'(bus.cli_grant),   0);
    chk({tag, ".wrdone"},  32'(bus.cli_wr_done), 0);
    chk({tag, ".data"},    32'(bus.data),        0);
    chk({tag, ".enwr"},    32'(bus.en_write),    0);
    chk({tag, ".busy"},    32'(bus.busy),        0);
    chk({tag, ".timeout"}, 32'(bus.timeout_err), 0);
  endtask

  initial begin
    bus.init_done = 1'b0;
    bus.cli_req   = '0;
    bus.cli_en    = '0;
    bus.cli_data  = '0;
    bus.wr_done   = 1'b0;

    // Reset
    tick(); tick();
    rst = 1'b0;
    chk_idle_outputs("reset");

    // Pre-init gating
    bus.cli_req = 3'b110;
    tick(); chk("preinit_gate1", 32'(bus.cli_grant), 0);
    tick(); chk("preinit_gate2", 32'(bus.cli_grant), 0);
    bus.cli_req = 3'b111;
    tick(); chk("preinit_grant0", 32'(bus.cli_grant), 32'b001);
    chk("preinit_busy", 32'(bus.busy), 1);

    // Write path for client 0
    set_word(CLI_INIT, 9'h12A);
    bus.cli_en = 3'b001;
    tick();
    chk("wr0_en",   32'(bus.en_write), 1);
    chk("wr0_data", 32'(bus.data), 32'h12A);
    bus.cli_en = 3'b000;
    tick();
    chk("wr0_en_pulse", 32'(bus.en_write), 0);
    chk("wr0_data_hold", 32'(bus.data), 32'h12A);
    // Non-granted and granted strobes in WAIT_DONE are dropped
    set_word(CLI_PIC, 9'h055);
    set_word(CLI_INIT, 9'h0EE);
    bus.cli_en = 3'b011;
    tick();
    chk("wait_en_ignored", 32'(bus.en_write), 0);
    chk("wait_data_hold", 32'(bus.data), 32'h12A);
    bus.cli_en  = 3'b000;
    bus.wr_done = 1'b1;
    tick();
    chk("wr0_done", 32'(bus.cli_wr_done), 32'b001);
    chk("wr0_grant_kept", 32'(bus.cli_grant), 32'b001);
    // wr_done in GRANT is ignored
    tick();
    chk("stray_wrdone", 32'(bus.cli_wr_done), 0);
    bus.wr_done = 1'b0;
    tick();
    chk("wrdone_pulse_end", 32'(bus.cli_wr_done), 0);

    // Client 0 drops: RELEASE then IDLE
    bus.cli_req = 3'b110;
    tick();
    chk("rel_grant", 32'(bus.cli_grant), 0);
    chk("rel_busy", 32'(bus.busy), 1);
    tick();
    chk("idle_busy", 32'(bus.busy), 0);

    // Round-robin 010, 100, 010
    bus.init_done = 1'b1;
    tick();
    chk("rr_first", 32'(bus.cli_grant), 32'b010);
    set_word(CLI_PIC, 9'h0A5);
    bus.cli_en = 3'b010;
    tick();
    chk("rr1_data", 32'(bus.data), 32'h0A5);
    bus.cli_en  = 3'b000;
    bus.cli_req = 3'b100;
    tick();
    chk("rr1_wait_grant", 32'(bus.cli_grant), 32'b010);
    bus.wr_done = 1'b1;
    tick();
    chk("rr1_done", 32'(bus.cli_wr_done), 32'b010);
    chk("rr1_release", 32'(bus.cli_grant), 0);
    bus.wr_done = 1'b0;
    bus.cli_req = 3'b110;
    tick();
    chk("rr_gap1", 32'(bus.cli_grant), 0);
    tick();
    chk("rr_second", 32'(bus.cli_grant), 32'b100);
    set_word(CLI_CHAR, 9'h1F0);
    bus.cli_en = 3'b100;
    tick();
    chk("rr2_data", 32'(bus.data), 32'h1F0);
    bus.cli_en  = 3'b000;
    bus.cli_req = 3'b010;
    bus.wr_done = 1'b1;
    tick();
    chk("rr2_done", 32'(bus.cli_wr_done), 32'b100);
    chk("rr2_release", 32'(bus.cli_grant), 0);
    bus.wr_done = 1'b0;
    bus.cli_req = 3'b110;
    tick();
    chk("rr_gap2", 32'(bus.cli_grant), 0);
    tick();
    chk("rr_third", 32'(bus.cli_grant), 32'b010);

    // Burst lock: client 1 keeps the bus for 5 writes while client 0 waits
    bus.cli_req = 3'b111;
    for (int i = 0; i < 5; i++) begin
      set_word(CLI_PIC, 9'(9'h100 + i));
      bus.cli_en = 3'b010;
      tick();
      chk("burst_en",   32'(bus.en_write), 1);
      chk("burst_data", 32'(bus.data), 32'(9'h100 + i));
      bus.cli_en  = 3'b000;
      bus.wr_done = 1'b1;
      tick();
      chk("burst_done",  32'(bus.cli_wr_done), 32'b010);
      chk("burst_grant", 32'(bus.cli_grant), 32'b010);
      bus.wr_done = 1'b0;
    end
    bus.cli_req = 3'b101;
    tick();
    chk("burst_release", 32'(bus.cli_grant), 0);
    tick();
    chk("burst_gap", 32'(bus.cli_grant), 0);
    tick();
    chk("prio_client0", 32'(bus.cli_grant), 32'b001);

    // wr_done and cli_en coincide: strobe dropped
    set_word(CLI_INIT, 9'h033);
    bus.cli_en = 3'b001;
    tick();
    chk("coin_first", 32'(bus.data), 32'h033);
    set_word(CLI_INIT, 9'h044);
    bus.wr_done = 1'b1;
    tick();
    chk("coin_done", 32'(bus.cli_wr_done), 32'b001);
    chk("coin_en_dropped", 32'(bus.en_write), 0);
    chk("coin_data_hold", 32'(bus.data), 32'h033);
    bus.wr_done = 1'b0;
    bus.cli_en  = 3'b000;
    tick();
    chk("coin_no_late_write", 32'(bus.en_write), 0);

    // Mid-op reset during WAIT_DONE
    set_word(CLI_INIT, 9'h155);
    bus.cli_en = 3'b001;
    tick();
    chk("rst_pre_en", 32'(bus.en_write), 1);
    bus.cli_en  = 3'b000;
    bus.cli_req = 3'b000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_outputs("midop_rst");
    bus.wr_done = 1'b1;
    tick();
    chk("rst_no_wrdone", 32'(bus.cli_wr_done), 0);
    chk("rst_still_idle", 32'(bus.busy), 0);
    bus.wr_done = 1'b0;

    // Pointer back at client 1 after reset
    bus.cli_req = 3'b110;
    tick();
    chk("rst_ptr", 32'(bus.cli_grant), 32'b010);
    bus.cli_req = 3'b001;
    tick(); tick();
    tick();
    chk("wd_setup_grant", 32'(bus.cli_grant), 32'b001);

    // Watchdog / no-watchdog behaviour with no wr_done
    set_word(CLI_INIT, 9'h0C3);
    bus.cli_en = 3'b001;
    tick();
    bus.cli_en = 3'b000;
`ifdef LCD_ARB_WDOG_EN
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("wd_quiet", 32'(bus.timeout_err), 0);
    end
    tick();
    chk("wd_timeout", 32'(bus.timeout_err), 1);
    chk("wd_grant_drop", 32'(bus.cli_grant), 0);
    chk("wd_no_wrdone", 32'(bus.cli_wr_done), 0);
    tick();
    chk("wd_pulse_end", 32'(bus.timeout_err), 0);
`else
    for (int i = 0; i < 20; i++) tick();
    chk("nowd_timeout", 32'(bus.timeout_err), 0);
    chk("nowd_grant", 32'(bus.cli_grant), 32'b001);
    bus.wr_done = 1'b1;
    tick();
    chk("nowd_done", 32'(bus.cli_wr_done), 32'b001);
    bus.wr_done = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
